// File: rtl/bcd_updown_counter_if.sv
// Control and status bundle for bcd_updown_counter. The master drives the controls and
// the slave (the counter) returns the count and its limit flags.
interface bcd_updown_counter_if #(
    parameter int unsigned DIGITS = 2
);
    logic                  en;
    logic                  up_dn;
    logic                  sat_mode;
    logic                  load;
    logic [4*DIGITS-1:0]   load_value;
    logic [4*DIGITS-1:0]   count;
    logic                  tc;
    logic                  at_limit;

    modport master (
        output en, up_dn, sat_mode, load, load_value,
        input  count, tc, at_limit
    );

    modport slave (
        input  en, up_dn, sat_mode, load, load_value,
        output count, tc, at_limit
    );
endinterface

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with synchronous load, wrap or saturate at the limit,
// a combinational terminal count for cascading and a registered at-limit flag.
module bcd_updown_counter #(
    parameter int unsigned         DIGITS    = 2,
    parameter logic [4*DIGITS-1:0] RESET_VAL = '0
) (
    input logic                   clock,
    input logic                   reset_n,
    bcd_updown_counter_if.slave   bus
);
    localparam int unsigned         W         = 4 * DIGITS;
    localparam logic [W-1:0]        ALL_NINES = {DIGITS{4'h9}};

    function automatic logic [W-1:0] clamp_bcd(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = v;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
        end
        return r;
    endfunction

    localparam logic [W-1:0] RST_COUNT = clamp_bcd(RESET_VAL);

    logic [W-1:0] count_q, count_d;
    logic         at_limit_q, at_limit_d;
    logic         dir_limit;
    logic         carry;
    logic [3:0]   digit;
    logic [3:0]   digit_nxt;

    assign dir_limit = bus.up_dn ? (count_q == ALL_NINES) : (count_q == '0);

    always_comb begin
        count_d   = count_q;
        carry     = 1'b0;
        digit     = 4'd0;
        digit_nxt = 4'd0;
        if (bus.load) begin
            count_d = clamp_bcd(bus.load_value);
        end else if (bus.en && !(bus.sat_mode && dir_limit)) begin
            // Ripple carry/borrow across all digits; wrap at the limit falls out naturally.
            carry = 1'b1;
            for (int unsigned i = 0; i < DIGITS; i++) begin
                digit     = count_q[4*i +: 4];
                digit_nxt = digit;
                if (carry) begin
                    if (bus.up_dn) begin
                        if (digit == 4'd9) begin
                            digit_nxt = 4'd0;
                        end else begin
                            digit_nxt = digit + 4'd1;
                            carry     = 1'b0;
                        end
                    end else begin
                        if (digit == 4'd0) begin
                            digit_nxt = 4'd9;
                        end else begin
                            digit_nxt = digit - 4'd1;
                            carry     = 1'b0;
                        end
                    end
                end
                count_d[4*i +: 4] = digit_nxt;
            end
        end
    end

    assign at_limit_d = bus.up_dn ? (count_d == ALL_NINES) : (count_d == '0);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count_q    <= RST_COUNT;
            at_limit_q <= bus.up_dn ? (RST_COUNT == ALL_NINES) : (RST_COUNT == '0);
        end else begin
            count_q    <= count_d;
            at_limit_q <= at_limit_d;
        end
    end

    assign bus.count    = count_q;
    assign bus.at_limit = at_limit_q;
    assign bus.tc       = bus.en & dir_limit;
endmodule

// File: tb/tb_bcd_updown_counter.sv
// Scoreboard bench: a 2-digit and a 4-digit counter share one stimulus stream; an integer
// reference model queues expected results and a monitor compares them cycle by cycle.
module tb_bcd_updown_counter;
    logic        clock;
    logic        reset_n_s;
    logic        en_s, up_dn_s, sat_s, load_s;
    logic [15:0] lv_s;

    int compared   = 0;
    int mismatched = 0;

    bcd_updown_counter_if #(.DIGITS(2)) if2 ();
    bcd_updown_counter_if #(.DIGITS(4)) if4 ();

    assign if2.en = en_s;       assign if4.en = en_s;
    assign if2.up_dn = up_dn_s; assign if4.up_dn = up_dn_s;
    assign if2.sat_mode = sat_s; assign if4.sat_mode = sat_s;
    assign if2.load = load_s;   assign if4.load = load_s;
    assign if2.load_value = lv_s[7:0];
    assign if4.load_value = lv_s;

    bcd_updown_counter #(.DIGITS(2)) dut2 (.clock(clock), .reset_n(reset_n_s), .bus(if2));
    bcd_updown_counter #(.DIGITS(4)) dut4 (.clock(clock), .reset_n(reset_n_s), .bus(if4));

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        bit          chk_tc;
        bit          tc2;
        bit          tc4;
        logic [7:0]  c2;
        logic [15:0] c4;
        bit          al2;
        bit          al4;
    } exp_t;
    exp_t q[$];

    int m2, m4;
    bit known;

    function automatic int pow10(int nd);
        int r = 1;
        for (int i = 0; i < nd; i++) r = r * 10;
        return r;
    endfunction

    function automatic int load_int(logic [15:0] lv, int nd);
        int v = 0;
        int d;
        for (int i = nd - 1; i >= 0; i--) begin
            d = int'(lv[4*i +: 4]);
            if (d > 9) d = 9;
            v = v * 10 + d;
        end
        return v;
    endfunction

    function automatic logic [15:0] to_bcd(int v, int nd);
        logic [15:0] r = '0;
        int t = v;
        for (int i = 0; i < nd; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic int next_val(int v, int nd, bit rst_n, bit ld, logic [15:0] lv,
                                    bit e, bit ud, bit sm);
        int mx = pow10(nd) - 1;
        if (!rst_n) return 0;
        if (ld) return load_int(lv, nd);
        if (!e) return v;
        if (ud) return (v == mx) ? (sm ? v : 0) : v + 1;
        return (v == 0) ? (sm ? v : mx) : v - 1;
    endfunction

    task automatic cycle(bit rst_n, bit ld, logic [15:0] lv, bit e, bit ud, bit sm);
        exp_t x;
        @(negedge clock);
        reset_n_s = rst_n; load_s = ld; lv_s = lv; en_s = e; up_dn_s = ud; sat_s = sm;
        x.chk_tc = known;
        x.tc2 = e && (ud ? (m2 == 99) : (m2 == 0));
        x.tc4 = e && (ud ? (m4 == 9999) : (m4 == 0));
        m2 = next_val(m2, 2, rst_n, ld, lv, e, ud, sm);
        m4 = next_val(m4, 4, rst_n, ld, lv, e, ud, sm);
        if (!rst_n) known = 1'b1;
        x.c2  = to_bcd(m2, 2) & 16'h00ff;
        x.c4  = to_bcd(m4, 4);
        x.al2 = ud ? (m2 == 99) : (m2 == 0);
        x.al4 = ud ? (m4 == 9999) : (m4 == 0);
        q.push_back(x);
    endtask

    task automatic check(string name, logic [15:0] act, logic [15:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: tc is checked mid-cycle with the inputs applied, state just after the edge.
    initial begin
        exp_t x;
        forever begin
            @(negedge clock);
            #2;
            if (q.size() != 0) begin
                x = q.pop_front();
                if (x.chk_tc) begin
                    check("tc2", {15'd0, if2.tc}, {15'd0, x.tc2});
                    check("tc4", {15'd0, if4.tc}, {15'd0, x.tc4});
                end
                @(posedge clock);
                #1;
                check("count2", {8'd0, if2.count}, {8'd0, x.c2});
                check("count4", if4.count, x.c4);
                check("at_limit2", {15'd0, if2.at_limit}, {15'd0, x.al2});
                check("at_limit4", {15'd0, if4.at_limit}, {15'd0, x.al4});
            end
        end
    end

    initial begin
        reset_n_s = 1'b0; en_s = 1'b0; up_dn_s = 1'b1; sat_s = 1'b0; load_s = 1'b0;
        lv_s = '0; m2 = 0; m4 = 0; known = 1'b0;

        // Reset then full up-count with wrap.
        repeat (2) cycle(0, 0, 16'h0, 1, 1, 0);
        repeat (101) cycle(1, 0, 16'h0, 1, 1, 0);
        // Load wins over enable; invalid digits clamp to 9.
        cycle(1, 1, 16'h0042, 1, 1, 0);
        cycle(1, 1, 16'h00a7, 0, 1, 0);
        // Down wrap, then saturate at zero.
        cycle(1, 1, 16'h0001, 0, 0, 0);
        repeat (3) cycle(1, 0, 16'h0, 1, 0, 0);
        cycle(1, 1, 16'h0000, 0, 0, 1);
        repeat (3) cycle(1, 0, 16'h0, 1, 0, 1);
        // Saturate going up, then reverse.
        cycle(1, 1, 16'h0097, 0, 1, 1);
        repeat (4) cycle(1, 0, 16'h0, 1, 1, 1);
        cycle(1, 0, 16'h0, 1, 0, 1);
        // Reset mid-count takes priority over a step.
        cycle(1, 1, 16'h0056, 0, 1, 0);
        cycle(1, 0, 16'h0, 1, 1, 0);
        cycle(0, 0, 16'h0, 1, 1, 0);
        // Multi-digit ripple and hold.
        cycle(1, 1, 16'h0999, 0, 1, 0);
        cycle(1, 0, 16'h0, 1, 1, 0);
        cycle(1, 1, 16'h1000, 0, 0, 0);
        cycle(1, 0, 16'h0, 1, 0, 0);
        repeat (5) cycle(1, 0, 16'h0, 0, 1, 0);
        cycle(1, 1, 16'h9999, 0, 1, 0);
        cycle(1, 0, 16'h0, 1, 1, 0);
        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(39) != 0), ($urandom_range(7) == 0), 16'($urandom),
                  ($urandom_range(3) != 0), 1'($urandom), 1'($urandom));
        end

        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clock);
        if (q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        @(posedge clock);
        #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
